// File: rtl/secuencia_pintar_if.sv
// Request/display bundle between the game master FSM and the display sequencer.
// The master drives the paint/reset-paint requests and the LFSR word; the sequencer drives LEDs and status.
interface secuencia_pintar_if #(
    parameter int PASOS = 4
);
    logic               iPintar;
    logic               iResetPintar;
    logic [2*PASOS-1:0] iDato;
    logic [3:0]         oLed;
    logic               oStop;
    logic               oBusy;

    modport master (
        output iPintar, iResetPintar, iDato,
        input  oLed, oStop, oBusy
    );

    modport slave (
        input  iPintar, iResetPintar, iDato,
        output oLed, oStop, oBusy
    );
endinterface

// File: rtl/secuencia_pintar.sv
// Display sequencer: latches an LFSR word on a paint request and shows it as timed one-hot
// symbols on the LEDs, then holds a stop flag until the master sends reset-paint.
module secuencia_pintar #(
    parameter int PASOS      = 4,
    parameter int TIEMPO_ON  = 25_000_000,
    parameter int TIEMPO_OFF = 12_500_000
) (
    input  logic              iClk,
    input  logic              iReset,
    secuencia_pintar_if.slave bus
);

    localparam int MAX_T  = (TIEMPO_ON > TIEMPO_OFF) ? TIEMPO_ON : TIEMPO_OFF;
    localparam int CNT_W  = (MAX_T > 1) ? $clog2(MAX_T) : 1;
    localparam int PASO_W = (PASOS > 1) ? $clog2(PASOS) : 1;
    localparam int DW     = 2 * PASOS;

    localparam logic [CNT_W-1:0]  ON_ULT   = CNT_W'(TIEMPO_ON - 1);
    localparam logic [CNT_W-1:0]  OFF_ULT  = CNT_W'(TIEMPO_OFF - 1);
    localparam logic [PASO_W-1:0] PASO_ULT = PASO_W'(PASOS - 1);

    typedef enum logic [1:0] {
        REPOSO    = 2'd0,
        ENCENDIDO = 2'd1,
        APAGADO   = 2'd2,
        FIN       = 2'd3
    } estado_t;

    estado_t           estado_q, estado_d;
    logic [DW-1:0]     datos_q,  datos_d;
    logic [PASO_W-1:0] paso_q,   paso_d;
    logic [CNT_W-1:0]  cuenta_q, cuenta_d;
    logic [3:0]        led;

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            estado_q <= REPOSO;
            datos_q  <= '0;
            paso_q   <= '0;
            cuenta_q <= '0;
        end else begin
            estado_q <= estado_d;
            datos_q  <= datos_d;
            paso_q   <= paso_d;
            cuenta_q <= cuenta_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        datos_d  = datos_q;
        paso_d   = paso_q;
        cuenta_d = cuenta_q;

        // Reset-paint overrides everything, including a simultaneous paint request.
        if (bus.iResetPintar) begin
            estado_d = REPOSO;
            datos_d  = '0;
            paso_d   = '0;
            cuenta_d = '0;
        end else begin
            case (estado_q)
                REPOSO: begin
                    if (bus.iPintar) begin
                        estado_d = ENCENDIDO;
                        datos_d  = bus.iDato;
                        paso_d   = '0;
                        cuenta_d = '0;
                    end
                end
                ENCENDIDO: begin
                    if (cuenta_q == ON_ULT) begin
                        cuenta_d = '0;
                        estado_d = APAGADO;
                    end else begin
                        cuenta_d = cuenta_q + CNT_W'(1);
                    end
                end
                APAGADO: begin
                    if (cuenta_q == OFF_ULT) begin
                        cuenta_d = '0;
                        if (paso_q == PASO_ULT) begin
                            estado_d = FIN;
                        end else begin
                            paso_d   = paso_q + PASO_W'(1);
                            datos_d  = datos_q << 2;
                            estado_d = ENCENDIDO;
                        end
                    end else begin
                        cuenta_d = cuenta_q + CNT_W'(1);
                    end
                end
                FIN: begin
                    estado_d = FIN;
                end
                default: begin
                    estado_d = REPOSO;
                end
            endcase
        end
    end

    // The top two bits of the shift register select which LED is lit.
    always_comb begin
        led = 4'b0000;
        if (estado_q == ENCENDIDO) begin
            led = 4'b0001 << datos_q[DW-1 -: 2];
        end
    end

    assign bus.oLed  = led;
    assign bus.oStop = (estado_q == FIN);
    assign bus.oBusy = (estado_q == ENCENDIDO) || (estado_q == APAGADO);

endmodule

// File: tb/tb_secuencia_pintar.sv
// Bench for secuencia_pintar: table of directed vectors, hand-written corner sequences,
// then random requests compared against a timeline-based reference model.
module tb_secuencia_pintar;

    localparam int PASOS = 4;
    localparam int T_ON  = 3;
    localparam int T_OFF = 2;
    localparam int TOTAL = PASOS * (T_ON + T_OFF);

    logic clk;
    logic rst;

    secuencia_pintar_if #(.PASOS(PASOS)) bus ();

    secuencia_pintar #(
        .PASOS     (PASOS),
        .TIEMPO_ON (T_ON),
        .TIEMPO_OFF(T_OFF)
    ) dut (
        .iClk  (clk),
        .iReset(rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: a sequence is just "cycles elapsed since acceptance" plus the latched word.
    bit         m_run;
    int         m_t;
    logic [7:0] m_w;

    function automatic logic [5:0] model_exp();
        int         stp;
        int         ph;
        logic [1:0] dig;
        if (!m_run) return 6'b000000;
        if (m_t >= TOTAL) return 6'b000010;
        stp = m_t / (T_ON + T_OFF);
        ph  = m_t % (T_ON + T_OFF);
        dig = 2'((m_w >> (6 - 2 * stp)) & 8'h03);
        if (ph < T_ON) return {4'(4'b0001 << dig), 1'b0, 1'b1};
        return 6'b000001;
    endfunction

    task automatic model_edge(input logic p, input logic rp, input logic [7:0] d);
        if (rp) begin
            m_run = 0;
            m_t   = 0;
        end else if (!m_run && p) begin
            m_run = 1;
            m_t   = 0;
            m_w   = d;
        end else if (m_run && m_t < TOTAL) begin
            m_t++;
        end
    endtask

    task automatic check(input string name, input logic [5:0] exp);
        logic [5:0] got;
        got = {bus.oLed, bus.oStop, bus.oBusy};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got led=%b stop=%b busy=%b expected led=%b stop=%b busy=%b",
                     name, $time, got[5:2], got[1], got[0], exp[5:2], exp[1], exp[0]);
        end
    endtask

    task automatic step(input logic p, input logic rp, input logic [7:0] d);
        @(negedge clk);
        bus.iPintar      = p;
        bus.iResetPintar = rp;
        bus.iDato        = d;
        @(posedge clk);
        model_edge(p, rp, d);
        #1;
    endtask

    typedef struct {
        int         n;
        logic       p;
        logic       rp;
        logic [7:0] d;
        logic [3:0] led;
        logic       stop;
        logic       busy;
    } vec_t;

    vec_t tbl [26];

    initial begin
        tbl[0]  = '{1,  1'b1, 1'b0, 8'b00_01_10_11, 4'b0001, 1'b0, 1'b1};
        tbl[1]  = '{2,  1'b0, 1'b0, 8'h00,          4'b0001, 1'b0, 1'b1};
        tbl[2]  = '{2,  1'b0, 1'b0, 8'h00,          4'b0000, 1'b0, 1'b1};
        tbl[3]  = '{3,  1'b0, 1'b0, 8'h00,          4'b0010, 1'b0, 1'b1};
        tbl[4]  = '{2,  1'b0, 1'b0, 8'h00,          4'b0000, 1'b0, 1'b1};
        tbl[5]  = '{3,  1'b0, 1'b0, 8'h00,          4'b0100, 1'b0, 1'b1};
        tbl[6]  = '{2,  1'b0, 1'b0, 8'h00,          4'b0000, 1'b0, 1'b1};
        tbl[7]  = '{3,  1'b0, 1'b0, 8'h00,          4'b1000, 1'b0, 1'b1};
        tbl[8]  = '{2,  1'b0, 1'b0, 8'h00,          4'b0000, 1'b0, 1'b1};
        tbl[9]  = '{50, 1'b0, 1'b0, 8'h00,          4'b0000, 1'b1, 1'b0};
        tbl[10] = '{1,  1'b0, 1'b1, 8'h00,          4'b0000, 1'b0, 1'b0};
        tbl[11] = '{3,  1'b0, 1'b0, 8'h00,          4'b0000, 1'b0, 1'b0};
        // Second run with an ignored re-request carrying a different word.
        tbl[12] = '{1,  1'b1, 1'b0, 8'b00_01_10_11, 4'b0001, 1'b0, 1'b1};
        tbl[13] = '{2,  1'b0, 1'b0, 8'h00,          4'b0001, 1'b0, 1'b1};
        tbl[14] = '{2,  1'b0, 1'b0, 8'h00,          4'b0000, 1'b0, 1'b1};
        tbl[15] = '{1,  1'b0, 1'b0, 8'h00,          4'b0010, 1'b0, 1'b1};
        tbl[16] = '{1,  1'b1, 1'b0, 8'hFF,          4'b0010, 1'b0, 1'b1};
        tbl[17] = '{1,  1'b0, 1'b0, 8'h00,          4'b0010, 1'b0, 1'b1};
        tbl[18] = '{2,  1'b0, 1'b0, 8'h00,          4'b0000, 1'b0, 1'b1};
        tbl[19] = '{3,  1'b0, 1'b0, 8'h00,          4'b0100, 1'b0, 1'b1};
        tbl[20] = '{2,  1'b0, 1'b0, 8'h00,          4'b0000, 1'b0, 1'b1};
        tbl[21] = '{3,  1'b0, 1'b0, 8'h00,          4'b1000, 1'b0, 1'b1};
        tbl[22] = '{2,  1'b0, 1'b0, 8'h00,          4'b0000, 1'b0, 1'b1};
        tbl[23] = '{2,  1'b1, 1'b0, 8'hFF,          4'b0000, 1'b1, 1'b0};
        tbl[24] = '{1,  1'b0, 1'b1, 8'h00,          4'b0000, 1'b0, 1'b0};
        tbl[25] = '{2,  1'b0, 1'b0, 8'h00,          4'b0000, 1'b0, 1'b0};

        m_run            = 0;
        m_t              = 0;
        m_w              = '0;
        rst              = 1'b1;
        bus.iPintar      = 1'b0;
        bus.iResetPintar = 1'b0;
        bus.iDato        = '0;

        // Reset state, then idle with no requests.
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 6'b000000);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 8'h00);
            check("idle_after_reset", 6'b000000);
        end

        // Directed table: full sequence, hold in FIN, reset-paint, ignored re-request.
        foreach (tbl[r]) begin
            for (int c = 0; c < tbl[r].n; c++) begin
                step(tbl[r].p, tbl[r].rp, tbl[r].d);
                check($sformatf("tbl_row%0d", r), {tbl[r].led, tbl[r].stop, tbl[r].busy});
            end
        end

        // Abort mid-sequence, then immediately restart with a new word.
        step(1'b1, 1'b0, 8'b00_01_10_11);
        check("abort_start", 6'b0001_0_1);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 8'h00);
        check("abort_before", 6'b0010_0_1);
        step(1'b0, 1'b1, 8'h00);
        check("abort_idle", 6'b0000_0_0);
        step(1'b1, 1'b0, 8'hFF);
        check("abort_restart", 6'b1000_0_1);
        step(1'b0, 1'b1, 8'h00);
        check("abort_cleanup", 6'b000000);

        // Reset-paint and paint in the same cycle: reset-paint wins.
        step(1'b1, 1'b1, 8'hA5);
        check("both_req", 6'b000000);
        step(1'b0, 1'b0, 8'h00);
        check("both_req_after", 6'b000000);

        // Asynchronous reset between edges while a symbol is lit.
        step(1'b1, 1'b0, 8'hC0);
        check("async_pre", 6'b1000_0_1);
        @(negedge clk);
        bus.iPintar = 1'b0;
        rst         = 1'b1;
        m_run       = 0;
        #1;
        check("async_immediate", 6'b000000);
        @(posedge clk);
        #1;
        check("async_held", 6'b000000);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 8'h00);
            check("async_no_resume", 6'b000000);
        end

        // Random master behaviour against the reference model.
        for (int i = 0; i < 600; i++) begin
            logic       p;
            logic       rp;
            logic [7:0] d;
            p  = ($urandom_range(0, 5) == 0);
            rp = ($urandom_range(0, 29) == 0) || (m_run && m_t >= TOTAL && $urandom_range(0, 3) == 0);
            d  = 8'($urandom);
            step(p, rp, d);
            check("random", model_exp());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/secuencia_pintar.md
# secuencia_pintar

Display sequencer that answers the game master FSM's paint/reset requests. When the master issues a paint pulse, the block latches the current LFSR word and shows it on the LEDs as a timed series of one-hot symbols. When the series ends it raises a stop flag, which is the master's stop input. It stays in that finished state until the master's reset-paint pulse returns it to idle.

## Interface
Parameters:
- PASOS, 4, number of symbols shown per sequence (≥1).
- TIEMPO_ON, 25_000_000, clock cycles each symbol is lit (≥1).
- TIEMPO_OFF, 12_500_000, clock cycles of blank gap after each symbol (≥1).

Ports:
- iClk  in  1  system clock, rising edge.
- iReset  in  1  asynchronous, active-high reset.
- iPintar  in  1  start request from master; one-cycle pulse, level tolerated.
- iResetPintar  in  1  return-to-idle request from master; one-cycle pulse.
- iDato  in  2*PASOS  LFSR word, sampled only on an accepted iPintar.
- oLed  out  4  one-hot symbol display.
- oStop  out  1  sequence finished; feeds master iStop.
- oBusy  out  1  sequence in progress.

## Operation
- States:
  - REPOSO (idle)
  - ENCENDIDO (symbol lit)
  - APAGADO (gap)
  - FIN (finished)
- Internal registers:
  - `estado`
  - shift register `datos` [2*PASOS-1:0]
  - step counter `paso` (0..PASOS-1)
  - cycle counter `cuenta`, wide enough for max(TIEMPO_ON, TIEMPO_OFF)-1.
- REPOSO: on iPintar=1, load datos←iDato, paso←0, cuenta←0, go ENCENDIDO. Otherwise stay.
- ENCENDIDO: oLed = 1 << datos[2*PASOS-1 : 2*PASOS-2], so 00→0001, 01→0010, 10→0100, 11→1000.
  - cuenta increments each cycle.
  - When cuenta==TIEMPO_ON-1: cuenta←0, go APAGADO.
- APAGADO: oLed=0, cuenta increments. When cuenta==TIEMPO_OFF-1, cuenta←0, then:
  - if paso==PASOS-1, go FIN;
  - else paso←paso+1, datos←datos<<2 (zero fill), go ENCENDIDO.
- FIN: oStop=1, oLed=0. Stays in FIN until iResetPintar.
- iResetPintar=1 in any state: next state REPOSO, with cuenta, paso and datos cleared. It has priority over iPintar in the same cycle.
- iPintar while in ENCENDIDO, APAGADO or FIN is ignored; iDato is not resampled.
- Outputs are decoded only from registered state (Moore), with no combinational path from inputs:
  - oBusy = state is ENCENDIDO or APAGADO;
  - oStop = state is FIN.
- Reset values: estado=REPOSO, datos=0, paso=0, cuenta=0, giving oLed=0000, oStop=0, oBusy=0.
- iReset asserted mid-sequence forces the reset values immediately (asynchronous). The sequence does not resume after reset.

## Timing
- Latency: iPintar sampled high at rising edge k → ENCENDIDO and first symbol visible from k+1.
- Each symbol is lit for exactly TIEMPO_ON cycles, then blank for exactly TIEMPO_OFF cycles.
- Full sequence: PASOS*(TIEMPO_ON+TIEMPO_OFF) cycles. oStop rises at edge k+1+PASOS*(TIEMPO_ON+TIEMPO_OFF).
- iResetPintar sampled at edge m → oStop=0 and oBusy=0 from m+1. A new iPintar is accepted from edge m+1 onward.
- Master handshake: master pulses iPintar for one cycle, waits on oStop, then pulses iResetPintar. The block holds oStop high indefinitely until that pulse arrives.
- Counter wrap: cuenta never exceeds max(TIEMPO_ON, TIEMPO_OFF)-1. paso never exceeds PASOS-1.

## Test plan
Bench parameters: PASOS=4, TIEMPO_ON=3, TIEMPO_OFF=2.
1. Reset and iPintar held 0: release iReset → oLed=0000, oStop=0, oBusy=0 for 20 cycles.
2. Full sequence: iDato=8'b00_01_10_11, iPintar pulse at edge k →
   - oLed=0001 at k+1..k+3, 0000 at k+4..k+5;
   - 0010 at k+6..k+8, gap;
   - 0100 at k+11..k+13, gap;
   - 1000 at k+16..k+18;
   - oStop=1 from k+21; oBusy=1 over k+1..k+20.
3. Hold in FIN: after scenario 2, wait 50 cycles → oStop stays 1, oLed=0000. iResetPintar pulse at m → oStop=0 at m+1.
4. Ignored request: iPintar re-pulsed at k+7 with iDato=8'hFF → sequence identical to scenario 2.
5. Abort: iResetPintar at k+8 → oLed=0000, oBusy=0 at k+9. New iPintar with iDato=8'hFF at k+9 → oLed=1000 at k+10.
6. Asynchronous reset mid-sequence: iReset asserted between edges during ENCENDIDO → outputs clear before the next edge. Also pulse iResetPintar and iPintar together in REPOSO → block stays in REPOSO.
